// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the five-stage RV32IM pipeline: per-stage hold/flush from busywait, redirect, divide and load-use.
// Optional multi-cycle divide sequencer enabled by defining PIPELINE_CTRL_DIV_EN.
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_imem_busywait,
  input  logic       i_dmem_busywait,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_memread,
  input  logic       i_ex_redirect,
  input  logic       i_ex_div_start,
  output logic       o_pc_hold,
  output logic       o_if_id_hold,
  output logic       o_id_ex_hold,
  output logic       o_ex_mem_hold,
  output logic       o_mem_wb_hold,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_flush,
  output logic       o_div_busy,
  output logic       o_div_done
);

  logic w_gstall;
  logic w_load_use;
  logic w_div_hold;
  logic w_div_busy;
  logic w_div_done;

  assign w_gstall = i_imem_busywait | i_dmem_busywait;

  assign w_load_use = i_ex_memread && (i_ex_rd != 5'd0) &&
                      ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

`ifdef PIPELINE_CTRL_DIV_EN
  typedef enum logic {
    S_IDLE,
    S_BUSY
  } div_state_t;

  div_state_t r_state;
  logic [5:0] r_cnt;

  // A memory stall freezes the divider exactly like every other stage; redirect beats a start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else if (!w_gstall) begin
      case (r_state)
        S_IDLE: begin
          if (i_ex_div_start && !i_ex_redirect) begin
            r_state <= S_BUSY;
            r_cnt   <= 6'(DIV_CYCLES - 2);
          end
        end
        S_BUSY: begin
          if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_div_busy = (r_state == S_BUSY);
  assign w_div_hold = ((r_state == S_IDLE) && i_ex_div_start && !i_ex_redirect) ||
                      ((r_state == S_BUSY) && (r_cnt != 6'd0));
  assign w_div_done = (r_state == S_BUSY) && (r_cnt == 6'd0) && !w_gstall;
`else
  logic w_unused;

  assign w_unused   = i_ex_div_start | (DIV_CYCLES < 2);
  assign w_div_busy = 1'b0;
  assign w_div_hold = 1'b0;
  assign w_div_done = 1'b0;
`endif

  // Single priority chain: reset, global stall, redirect, divide, load-use.
  always_comb begin
    o_pc_hold      = 1'b0;
    o_if_id_hold   = 1'b0;
    o_id_ex_hold   = 1'b0;
    o_ex_mem_hold  = 1'b0;
    o_mem_wb_hold  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    if (i_reset) begin
      o_pc_hold = 1'b0;
    end else if (w_gstall) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_hold  = 1'b1;
      o_ex_mem_hold = 1'b1;
      o_mem_wb_hold = 1'b1;
    end else if (i_ex_redirect) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_div_hold) begin
      o_pc_hold      = 1'b1;
      o_if_id_hold   = 1'b1;
      o_id_ex_hold   = 1'b1;
      o_ex_mem_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  assign o_div_busy = !i_reset && w_div_busy;
  assign o_div_done = !i_reset && w_div_done;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with DIV_CYCLES=4; divide vectors follow PIPELINE_CTRL_DIV_EN.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       imemBusywait, dmemBusywait;
  logic [4:0] idRs1, idRs2, exRd;
  logic       idUsesRs1, idUsesRs2, exMemread, exRedirect, exDivStart;
  logic       pcHold, ifIdHold, idExHold, exMemHold, memWbHold;
  logic       ifIdFlush, idExFlush, exMemFlush, divBusy, divDone;
  logic [9:0] outs;

  int compared   = 0;
  int mismatched = 0;

  // Output vector order: holds pc,if_id,id_ex,ex_mem,mem_wb | flushes if_id,id_ex,ex_mem | busy | done
  localparam logic [9:0] NONE  = 10'b00000_000_0_0;
  localparam logic [9:0] ALLH  = 10'b11111_000_0_0;
  localparam logic [9:0] ALLHB = 10'b11111_000_1_0;
  localparam logic [9:0] LU    = 10'b11000_010_0_0;
  localparam logic [9:0] RD    = 10'b00000_110_0_0;
  localparam logic [9:0] DH    = 10'b11100_001_0_0;
  localparam logic [9:0] DHB   = 10'b11100_001_1_0;
  localparam logic [9:0] DONE  = 10'b00000_000_1_1;

  assign outs = {pcHold, ifIdHold, idExHold, exMemHold, memWbHold,
                 ifIdFlush, idExFlush, exMemFlush, divBusy, divDone};

  pipeline_ctrl #(.DIV_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_imem_busywait(imemBusywait), .i_dmem_busywait(dmemBusywait),
    .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_uses_rs1(idUsesRs1), .i_id_uses_rs2(idUsesRs2),
    .i_ex_rd(exRd), .i_ex_memread(exMemread),
    .i_ex_redirect(exRedirect), .i_ex_div_start(exDivStart),
    .o_pc_hold(pcHold), .o_if_id_hold(ifIdHold), .o_id_ex_hold(idExHold),
    .o_ex_mem_hold(exMemHold), .o_mem_wb_hold(memWbHold),
    .o_if_id_flush(ifIdFlush), .o_id_ex_flush(idExFlush), .o_ex_mem_flush(exMemFlush),
    .o_div_busy(divBusy), .o_div_done(divDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  // Inputs are driven 1ns after a rising edge; outputs are sampled mid-cycle, then we move to the next cycle.
  task automatic applyStimulus(input string tag, input logic [9:0] expected);
    #4;
    checkOutput(tag, outs, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    imemBusywait = 0; dmemBusywait = 0;
    idRs1 = 0; idRs2 = 0; exRd = 0;
    idUsesRs1 = 0; idUsesRs2 = 0;
    exMemread = 0; exRedirect = 0; exDivStart = 0;
  endtask

  initial begin
    clearInputs();
    reset = 1;
    @(posedge clk);
    #1;

    exMemread = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    applyStimulus("reset_cycle0", NONE);
    applyStimulus("reset_cycle1", NONE);
    reset = 0;
    applyStimulus("loaduse_after_reset", LU);
    exMemread = 0;
    applyStimulus("loaduse_cleared", NONE);

    exMemread = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
    applyStimulus("load_to_x0", NONE);
    idUsesRs1 = 0; exRd = 7; idRs2 = 7; idUsesRs2 = 0;
    applyStimulus("rs2_not_used", NONE);
    idUsesRs2 = 1;
    applyStimulus("loaduse_rs2", LU);
    exRedirect = 1;
    applyStimulus("redirect_beats_loaduse", RD);
    imemBusywait = 1;
    applyStimulus("imem_beats_redirect", ALLH);
    clearInputs();
    dmemBusywait = 1;
    applyStimulus("dmem_stall", ALLH);
    clearInputs();
    applyStimulus("quiet", NONE);

`ifdef PIPELINE_CTRL_DIV_EN
    exDivStart = 1;
    applyStimulus("div_T0", DH);
    applyStimulus("div_T1", DHB);
    applyStimulus("div_T2", DHB);
    applyStimulus("div_T3_done", DONE);
    applyStimulus("div2_start_b2b", DH);
    dmemBusywait = 1;
    applyStimulus("div2_stall1", ALLHB);
    applyStimulus("div2_stall2", ALLHB);
    dmemBusywait = 0;
    applyStimulus("div2_T3", DHB);
    applyStimulus("div2_T4", DHB);
    applyStimulus("div2_T5_done", DONE);
    exDivStart = 0;
    applyStimulus("div2_idle", NONE);

    exRedirect = 1; exDivStart = 1;
    applyStimulus("redirect_with_start", RD);
    exRedirect = 0; exDivStart = 0;
    applyStimulus("fsm_stayed_idle", NONE);

    exDivStart = 1;
    applyStimulus("div3_T0", DH);
    reset = 1;
    applyStimulus("div3_reset", NONE);
    reset = 0; exDivStart = 0;
    applyStimulus("div3_idle_after_reset", NONE);
    applyStimulus("div3_no_done", NONE);
`else
    exDivStart = 1;
    applyStimulus("nodiv_start", NONE);
    applyStimulus("nodiv_start_again", NONE);
    exRedirect = 1;
    applyStimulus("nodiv_redirect", RD);
    clearInputs();
    applyStimulus("nodiv_idle", NONE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
